ahb_lite_initiator: RTL and testbench

Bus initiator for the peripheral register bus (hsel/hwrite/haddr/hwdata/hrdata). It turns single or incrementing-burst commands from a local controller into the two-cycle peripheral access:
- cycle 1: hsel high, with address and data presented;
- cycle 2: hsel low, address and data held; the slave writes or the initiator samples hrdata.
It sits between the control sequencer and the register-mapped peripherals (e.g. the 8×16-bit parameter block and its read-only status words).

---
 rtl/ahb_lite_initiator.sv | 157 +++++++++++++++
 tb/tb_ahb_lite_initiator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_initiator.sv
// ahb_lite_initiator
// Turns single or incrementing-burst commands from a local controller into
// two-cycle peripheral register-bus accesses. Each beat takes one cycle with
// hsel high and the address/data presented, then one cycle with hsel low and
// address/data held while the slave commits a write or hrdata is sampled.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (accepted only when idle)
//   cmd_write/addr/len         direction, first byte address, beats minus one
//   wd_valid/wd_data/wd_ready  write-data beat stream
//   rd_valid/rd_data/rd_last   read-data beat stream, rd_ready consumes
//   done                       one-cycle pulse when a command completes
//   busy                       high whenever not idle
//   hsel/hwrite/haddr/hwdata   registered bus outputs
//   hrdata                     bus read data from the slave
module ahb_lite_initiator #(
    parameter int unsigned LEN_W     = 4,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wd_valid,
    input  logic [31:0]      wd_data,
    output logic             wd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    input  logic             rd_ready,
    output logic             done,
    output logic             busy,
    output logic             hsel,
    output logic             hwrite,
    output logic [31:0]      haddr,
    output logic [31:0]      hwdata,
    input  logic [31:0]      hrdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             hsel_q, hsel_d;

    logic last_beat;
    assign last_beat = (rem_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        rdata_d = rdata_q;
        hsel_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    write_d = cmd_write;
                    rem_d   = cmd_len;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // hsel is registered, so it is raised on the transition into ADDR.
                if (!write_q || wd_valid) begin
                    if (write_q) begin
                        wdata_d = wd_data;
                    end
                    hsel_d  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (!write_q) begin
                    rdata_d = hrdata;
                    state_d = S_RESP;
                end else if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_STEP;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_RESP: begin
                if (rd_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rem_q   <= '0;
            rdata_q <= '0;
            hsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rem_q   <= rem_d;
            rdata_q <= rdata_d;
            hsel_q  <= hsel_d;
        end
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign wd_ready  = (state_q == S_LOAD) && write_q;
    assign rd_valid  = (state_q == S_RESP);
    assign rd_last   = (state_q == S_RESP) && last_beat;
    assign rd_data   = rdata_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign hsel      = hsel_q;
    assign hwrite    = write_q;
    assign haddr     = addr_q;
    assign hwdata    = wdata_q;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
module tb_ahb_lite_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wd_valid = 1'b0;
    logic [31:0] wd_data = '0;
    logic        wd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_ready = 1'b0;
    logic        done;
    logic        busy;
    logic        hsel;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ahb_lite_initiator #(.LEN_W(4), .ADDR_STEP(32'd4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .busy(busy),
        .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata)
    );

    // Slave: 16 words indexed by haddr[5:2], preset to 0x98+i on reset
    // (so words 8..11 hold 0xA0..0xA3). Writes commit in the cycle after hsel.
    logic [31:0] mem [16];
    logic        sel_d;
    assign hrdata = mem[haddr[5:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_d <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h98 + 32'(i);
        end else begin
            if (sel_d && hwrite) mem[haddr[5:2]] <= hwdata;
            sel_d <= hsel;
        end
    end

    typedef struct {
        logic            wr;
        logic [31:0]     addr;
        logic [3:0]      len;
        int unsigned     gap;
        int unsigned     stall;
        logic [3:0][31:0] ha;
        logic [3:0][31:0] data;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                                input int unsigned gap, input int unsigned stall,
                                input logic [31:0] h0, input logic [31:0] h1,
                                input logic [31:0] h2, input logic [31:0] h3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.gap = gap; v.stall = stall;
        v.ha[0] = h0; v.ha[1] = h1; v.ha[2] = h2; v.ha[3] = h3;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input vec_t v);
        int unsigned hcnt = 0, wcnt = 0, rcnt = 0, gcnt = 0, scnt = 0, cyc = 0, last_h = 0;
        bit seen_h = 0, prev_h = 0, fin = 0;
        logic [31:0] prev_addr = '0, prev_wd = '0;
        int unsigned guard = 0;
        while (!cmd_ready && guard < 20) begin tick(); guard++; end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        tick();
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        while (!fin && cyc < 200) begin
            if (hsel) begin
                check("hsel_count_le_len", 32'(hcnt <= 32'(v.len)), 1);
                if (hcnt <= 32'(v.len)) begin
                    check("haddr", haddr, v.ha[hcnt]);
                    check("hwrite", hwrite, v.wr);
                    if (v.wr) begin
                        check("hwdata_addr_cycle", hwdata, v.data[hcnt]);
                        check("wd_before_hsel", wcnt, hcnt + 1);
                    end else begin
                        check("rd_before_hsel", rcnt, hcnt);
                    end
                end
                if (seen_h) check("hsel_spacing", 32'((cyc - last_h) >= 3), 1);
                seen_h = 1; last_h = cyc; hcnt++;
            end
            if (prev_h) begin
                check("hsel_one_cycle", hsel, 0);
                check("haddr_held", haddr, prev_addr);
                check("hwrite_held", hwrite, v.wr);
                if (v.wr) check("hwdata_held", hwdata, prev_wd);
            end
            prev_h = hsel; prev_addr = haddr; prev_wd = hwdata;

            if (!v.wr) check("wd_ready_on_read", wd_ready, 0);
            if (wd_ready && wcnt <= 32'(v.len)) begin
                if (gcnt < v.gap) begin
                    wd_valid = 1'b0; gcnt++;
                end else begin
                    wd_valid = 1'b1; wd_data = v.data[wcnt]; wcnt++; gcnt = 0;
                end
            end else begin
                wd_valid = 1'b0;
            end

            if (rd_valid && rcnt <= 32'(v.len)) begin
                check("rd_data", rd_data, v.data[rcnt]);
                check("rd_last", rd_last, 32'(rcnt == 32'(v.len)));
                if (rcnt == 0 && scnt < v.stall) begin
                    rd_ready = 1'b0; scnt++;
                    check("hsel_low_in_stall", hsel, 0);
                end else begin
                    rd_ready = 1'b1; rcnt++;
                end
            end else begin
                rd_ready = 1'b0;
            end

            if (done) begin
                fin = 1;
                check("hsel_pulses", hcnt, 32'(v.len) + 1);
                if (v.wr) begin
                    check("wd_beats", wcnt, 32'(v.len) + 1);
                    check("done_after_last_hsel", cyc - last_h, 2);
                end else begin
                    check("rd_beats", rcnt, 32'(v.len) + 1);
                end
            end
            tick();
            cyc++;
        end
        wd_valid = 1'b0; rd_ready = 1'b0;
        if (!fin) check("done_timeout", 0, 1);
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        vecs[0] = mk(1'b1, 32'h08, 4'd0, 0, 0, 32'h08, 0, 0, 0, 32'h1234, 0, 0, 0);
        vecs[1] = mk(1'b0, 32'h20, 4'd3, 0, 0, 32'h20, 32'h24, 32'h28, 32'h2C,
                     32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vecs[2] = mk(1'b0, 32'h08, 4'd0, 0, 0, 32'h08, 0, 0, 0, 32'h1234, 0, 0, 0);
        vecs[3] = mk(1'b0, 32'hFFFFFFFC, 4'd1, 0, 0, 32'hFFFFFFFC, 32'h0, 0, 0,
                     32'hA7, 32'h98, 0, 0);
        vecs[4] = mk(1'b1, 32'h31, 4'd2, 2, 0, 32'h31, 32'h35, 32'h39, 0,
                     32'h11, 32'h22, 32'h33, 0);
        vecs[5] = mk(1'b0, 32'h30, 4'd2, 0, 0, 32'h30, 32'h34, 32'h38, 0,
                     32'h11, 32'h22, 32'h33, 0);
        vecs[6] = mk(1'b0, 32'h20, 4'd1, 0, 5, 32'h20, 32'h24, 0, 0,
                     32'hA0, 32'hA1, 0, 0);

        // Outputs while held in reset.
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_hsel", hsel, 0);
        check("rst_haddr", haddr, 0);
        check("rst_done", done, 0);
        tick();
        rst = 1'b0;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        tick();

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Reset during the DATA cycle of beat 1 of a 4-beat write.
        begin
            int unsigned nh = 0;
            bit hit = 0, ph = 0;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_len = 4'd3;
            tick();
            cmd_valid = 1'b0;
            wd_valid = 1'b1; wd_data = 32'hC0;
            for (int c = 0; c < 40 && !hit; c++) begin
                if (hsel) nh++;
                if (nh == 2 && !hsel && ph) hit = 1;
                else begin ph = hsel; tick(); end
            end
            if (!hit) check("reset_test_reach_data", 0, 1);
            #2 rst = 1'b1;
            #1;
            check("arst_hsel", hsel, 0);
            check("arst_wd_ready", wd_ready, 0);
            check("arst_busy", busy, 0);
            check("arst_cmd_ready", cmd_ready, 0);
            check("arst_haddr", haddr, 0);
            check("arst_hwdata", hwdata, 0);
            check("arst_rd_valid", rd_valid, 0);
            wd_valid = 1'b0;
            for (int c = 0; c < 2; c++) begin
                tick();
                check("arst_no_done", done, 0);
                check("arst_no_busy", busy, 0);
            end
            rst = 1'b0;
            #1;
            check("post_rst_cmd_ready", cmd_ready, 1);
            check("post_rst_busy", busy, 0);
            tick();
            run_cmd(mk(1'b0, 32'h20, 4'd0, 0, 0, 32'h20, 0, 0, 0, 32'hA0, 0, 0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
